// File: rtl/gate_response_checker.sv
// gate_response_checker: checks a two-input gate's output against a golden
// model (AND/OR/XOR/NAND), counts accepted vectors and mismatches, and records
// the index of the first failing vector.
// Optional build macro: GATE_CHK_STOP_ON_FAIL_EN ends a run on the first mismatch.
module gate_response_checker #(
    parameter int N_VEC = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic             a,
    input  logic             b,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fail_valid,
    output logic [CNT_W-1:0] fail_idx
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [1:0]       op_r;

    // S1 capture stage
    logic             a_p1;
    logic             b_p1;
    logic             y_p1;
    logic [CNT_W-1:0] idx_p1;
    logic             vld_p1;

    logic             accept;
    logic             last_acc;
    logic             mism;
    logic             stop_hit;
    logic             drain_exit;

    function automatic logic gold(input logic [1:0] f, input logic x0, input logic x1);
        case (f)
            2'b00:   gold = x0 & x1;
            2'b01:   gold = x0 | x1;
            2'b10:   gold = x0 ^ x1;
            default: gold = ~(x0 & x1);
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // A start pulse takes priority: a vector offered in the same cycle is dropped.
    assign accept   = vec_valid && vec_ready && !start;
    assign last_acc = accept && (vec_cnt == CNT_W'(N_VEC - 1));
    assign mism     = vld_p1 && (y_p1 != gold(op_r, a_p1, b_p1));
    assign pass     = done && (err_cnt == '0);

`ifdef GATE_CHK_STOP_ON_FAIL_EN
    logic stop_r;

    assign stop_hit   = mism;
    // The vector still in S1 is compared on the same edge that enters DONE.
    assign drain_exit = !vld_p1 || stop_r;

    // Remember that the run was cut short by a mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_r <= 1'b0;
        end else if (start) begin
            stop_r <= 1'b0;
        end else if (state == RUN && mism) begin
            stop_r <= 1'b1;
        end
    end
`else
    assign stop_hit   = 1'b0;
    assign drain_exit = !vld_p1;
`endif

    // S1 data capture; only the valid bit is control, so data needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p1   <= a;
            b_p1   <= b;
            y_p1   <= y;
            idx_p1 <= vec_cnt;
        end
    end

    // Run FSM, S1 valid, compare stage and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_r       <= 2'b00;
            vld_p1     <= 1'b0;
            vec_ready  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            vec_cnt    <= '0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_idx   <= '0;
        end else if (start) begin
            state      <= RUN;
            op_r       <= op;
            vld_p1     <= 1'b0;
            vec_ready  <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            vec_cnt    <= '0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_idx   <= '0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                vec_cnt <= vec_cnt + CNT_W'(1);
            end
            if (mism) begin
                err_cnt <= sat_inc(err_cnt);
                if (!fail_valid) begin
                    fail_valid <= 1'b1;
                    fail_idx   <= idx_p1;
                end
            end
            case (state)
                RUN: begin
                    if (last_acc || stop_hit) begin
                        state     <= DRAIN;
                        vec_ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (drain_exit) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_response_checker.sv
// Scoreboard bench for gate_response_checker: each run's expected result is
// queued when the run is started, and monitors compare it when done rises.
module tb_gate_response_checker;

    typedef struct {
        logic [7:0] vc;
        logic [7:0] ec;
        logic       fv;
        logic [7:0] fi;
        logic       ps;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    // main instance (N_VEC=4, CNT_W=8)
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic       vec_valid = 1'b0;
    logic       a = 1'b0, b = 1'b0, y = 1'b0;
    logic       vec_ready, busy, done, pass, fail_valid;
    logic [7:0] vec_cnt, err_cnt, fail_idx;

    // small instance (N_VEC=3, CNT_W=2)
    logic       s_start = 1'b0;
    logic [1:0] s_op = 2'b00;
    logic       s_vv = 1'b0;
    logic       s_a = 1'b0, s_b = 1'b0, s_y = 1'b0;
    logic       s_ready, s_busy, s_done, s_pass, s_fv;
    logic [1:0] s_vc, s_ec, s_fi;

    int errors = 0;
    int checks = 0;
    res_t q_m[$];
    res_t q_s[$];
    logic done_d = 1'b0;
    logic s_done_d = 1'b0;

    always #5 clk = ~clk;

    gate_response_checker #(.N_VEC(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .vec_valid(vec_valid), .vec_ready(vec_ready),
        .a(a), .b(b), .y(y), .busy(busy), .done(done), .pass(pass),
        .vec_cnt(vec_cnt), .err_cnt(err_cnt),
        .fail_valid(fail_valid), .fail_idx(fail_idx)
    );

    gate_response_checker #(.N_VEC(3), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start), .op(s_op),
        .vec_valid(s_vv), .vec_ready(s_ready),
        .a(s_a), .b(s_b), .y(s_y), .busy(s_busy), .done(s_done), .pass(s_pass),
        .vec_cnt(s_vc), .err_cnt(s_ec),
        .fail_valid(s_fv), .fail_idx(s_fi)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic res_t mk(input int vc, input int ec, input logic fv, input int fi, input logic ps);
        res_t r;
        r.vc = 8'(vc); r.ec = 8'(ec); r.fv = fv; r.fi = 8'(fi); r.ps = ps;
        return r;
    endfunction

    // main monitor: compare against the queued result when done rises
    always @(negedge clk) begin
        res_t r;
        if (done && !done_d) begin
            if (q_m.size() == 0) begin
                check("main_unexpected_done", 32'd1, 32'd0);
            end else begin
                r = q_m.pop_front();
                check("main_vec_cnt", 32'(vec_cnt), 32'(r.vc));
                check("main_err_cnt", 32'(err_cnt), 32'(r.ec));
                check("main_fail_valid", 32'(fail_valid), 32'(r.fv));
                check("main_fail_idx", 32'(fail_idx), 32'(r.fi));
                check("main_pass", 32'(pass), 32'(r.ps));
            end
        end
        done_d = done;
    end

    // small-instance monitor
    always @(negedge clk) begin
        res_t r;
        if (s_done && !s_done_d) begin
            if (q_s.size() == 0) begin
                check("small_unexpected_done", 32'd1, 32'd0);
            end else begin
                r = q_s.pop_front();
                check("small_vec_cnt", 32'(s_vc), 32'(r.vc));
                check("small_err_cnt", 32'(s_ec), 32'(r.ec));
                check("small_fail_valid", 32'(s_fv), 32'(r.fv));
                check("small_fail_idx", 32'(s_fi), 32'(r.fi));
                check("small_pass", 32'(s_pass), 32'(r.ps));
            end
        end
        s_done_d = s_done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] f);
        op = f;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_vec(input logic va, input logic vb, input logic vy);
        int n;
        n = 0;
        while (!vec_ready && n < 20) begin
            tick();
            n++;
        end
        check("ready_before_send", 32'(vec_ready), 32'd1);
        a = va; b = vb; y = vy;
        vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!done && n < 50) begin
            tick();
            n++;
        end
        check(nm, 32'(done), 32'd1);
        tick();
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_ready"}, 32'(vec_ready), 32'd0);
        check({nm, "_busy"}, 32'(busy), 32'd0);
        check({nm, "_done"}, 32'(done), 32'd0);
        check({nm, "_pass"}, 32'(pass), 32'd0);
        check({nm, "_vec_cnt"}, 32'(vec_cnt), 32'd0);
        check({nm, "_err_cnt"}, 32'(err_cnt), 32'd0);
        check({nm, "_fail_valid"}, 32'(fail_valid), 32'd0);
        check({nm, "_fail_idx"}, 32'(fail_idx), 32'd0);
    endtask

    initial begin
        logic [2:0] sv [3];
        int acc;
        int n;
        logic rdy;

        // reset state
        tick();
        tick();
        check_zero("reset");
        check("small_reset_ready", 32'(s_ready), 32'd0);
        rst_n = 1'b1;
        tick();

        // vec_valid while IDLE is ignored
        a = 1'b1; b = 1'b1; y = 1'b0; vec_valid = 1'b1;
        tick(); tick();
        vec_valid = 1'b0;
        check("idle_ignore_vec_cnt", 32'(vec_cnt), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // run 1: AND, all correct, back-to-back, done latency
        q_m.push_back(mk(4, 0, 1'b0, 0, 1'b1));
        do_start(2'b00);
        check("run1_busy", 32'(busy), 32'd1);
        send_vec(0, 0, 0);
        send_vec(0, 1, 0);
        send_vec(1, 0, 0);
        send_vec(1, 1, 1);
        check("run1_ready_drop", 32'(vec_ready), 32'd0);
        check("run1_done_k", 32'(done), 32'd0);
        tick();
        check("run1_done_k1", 32'(done), 32'd0);
        tick();
        check("run1_done_k2", 32'(done), 32'd1);
        check("run1_busy_end", 32'(busy), 32'd0);
        tick();

        // run 2: XOR with one mismatch at index 2
        q_m.push_back(mk(4, 1, 1'b1, 2, 1'b0));
        do_start(2'b10);
        send_vec(0, 0, 0);
        send_vec(0, 1, 1);
        send_vec(1, 0, 0);
        send_vec(1, 1, 0);
        wait_done("run2_done");

        // run 3: OR with gaps, and stray vectors while DONE
        a = 1'b0; b = 1'b0; y = 1'b1; vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
        q_m.push_back(mk(4, 0, 1'b0, 0, 1'b1));
        do_start(2'b01);
        send_vec(0, 0, 0);
        tick();
        send_vec(0, 1, 1);
        tick(); tick();
        send_vec(1, 0, 1);
        tick();
        send_vec(1, 1, 1);
        wait_done("run3_done");
        a = 1'b1; b = 1'b0; y = 1'b0; vec_valid = 1'b1;
        tick(); tick(); tick();
        vec_valid = 1'b0;
        tick();
        check("done_ignore_vec_cnt", 32'(vec_cnt), 32'd4);
        check("done_ignore_err_cnt", 32'(err_cnt), 32'd0);
        check("done_ignore_pass", 32'(pass), 32'd1);
        check("done_ready_low", 32'(vec_ready), 32'd0);

        // restart mid-run: S1 flushed, vector offered with start is dropped
        do_start(2'b00);
        send_vec(0, 1, 1);
        send_vec(1, 0, 1);
        q_m.push_back(mk(4, 0, 1'b0, 0, 1'b1));
        a = 1'b1; b = 1'b1; y = 1'b0; vec_valid = 1'b1;
        do_start(2'b00);
        vec_valid = 1'b0;
        tick();
        check("restart_vec_cnt", 32'(vec_cnt), 32'd0);
        check("restart_err_cnt", 32'(err_cnt), 32'd0);
        check("restart_fail_valid", 32'(fail_valid), 32'd0);
        send_vec(0, 0, 0);
        send_vec(0, 1, 0);
        send_vec(1, 0, 0);
        send_vec(1, 1, 1);
        wait_done("restart_done");

        // reset mid-run after 2 accepts, then a fresh NAND run
        do_start(2'b00);
        send_vec(0, 1, 1);
        send_vec(1, 1, 1);
        tick();
        check("prereset_err_cnt", 32'(err_cnt), 32'd1);
        rst_n = 1'b0;
        #2;
        check_zero("midreset");
        tick();
        rst_n = 1'b1;
        tick();
        q_m.push_back(mk(4, 0, 1'b0, 0, 1'b1));
        do_start(2'b11);
        send_vec(0, 0, 1);
        send_vec(0, 1, 1);
        send_vec(1, 0, 1);
        send_vec(1, 1, 0);
        wait_done("postreset_done");

`ifdef GATE_CHK_STOP_ON_FAIL_EN
        // stop on first fail: mismatch on vector 1
        q_m.push_back(mk(3, 1, 1'b1, 1, 1'b0));
        do_start(2'b00);
        sv[0] = 3'b000; sv[1] = 3'b011; sv[2] = 3'b100;
        acc = 0;
        n = 0;
        while (acc < 4 && !done && n < 40) begin
            a = (acc == 3) ? 1'b1 : sv[acc][2];
            b = (acc == 3) ? 1'b1 : sv[acc][1];
            y = (acc == 3) ? 1'b1 : sv[acc][0];
            vec_valid = 1'b1;
            rdy = vec_ready;
            tick();
            if (rdy) acc++;
            n++;
        end
        vec_valid = 1'b0;
        check("stop_done_early", 32'(done), 32'd1);
        check("stop_accepted_le3", 32'(acc <= 3), 32'd1);
        tick();
`endif

        // small instance: NAND golden, device behaves as AND -> all mismatch
        q_s.push_back(mk(3, 3, 1'b1, 0, 1'b0));
        s_op = 2'b11;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        sv[0] = 3'b000; sv[1] = 3'b010; sv[2] = 3'b111;
        for (int i = 0; i < 3; i++) begin
            s_a = sv[i][2]; s_b = sv[i][1]; s_y = sv[i][0];
            s_vv = 1'b1;
            tick();
        end
        s_vv = 1'b0;
        n = 0;
        while (!s_done && n < 20) begin
            tick();
            n++;
        end
        check("small_done", 32'(s_done), 32'd1);
        tick(); tick();

        check("main_queue_drained", 32'(q_m.size()), 32'd0);
        check("small_queue_drained", 32'(q_s.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
